mac_sched: RTL and testbench

Two-requester scheduler that shares one 4x4-bit multiply-accumulate datapath. Each requester submits a job of LEN operand pairs over a valid/ready stream. The block arbitrates between jobs, clears the accumulator, feeds the operands, waits for the accumulator to settle and returns the 12-bit sum tagged with the requester id. It sits between the operand sources and the MAC datapath, and it is the only driver of the MAC control inputs.

---
 rtl/mac_pkg.sv | 18 +
 rtl/rr_arb2.sv | 67 ++++++
 rtl/mac_sched.sv | 177 +++++++++++++++++
 tb/tb_mac_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac_sched scheduler: datapath widths, the
// requester id width, the beat counter width and the FSM state encoding.
package mac_pkg;

    localparam int W_IN  = 4;   // operand width
    localparam int W_ACC = 12;  // accumulator / result width
    localparam int ID_W  = 1;   // requester id width (two requesters)
    localparam int CNT_W = 8;   // beat counter, covers LEN up to 255

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter used by mac_sched to pick the next job owner.
//
// Configuration macro: MAC_SCHED_PRIO_EN
//   undefined : round-robin. The pointed requester wins if it is requesting,
//               otherwise the other one. On advance the pointer moves to the
//               requester that did not own the finished job.
//   defined   : fixed priority, requester 0 wins whenever it requests; the
//               pointer is not consulted.
//
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   req[1:0]  request vector (bit N = requester N valid)
//   advance   one-cycle pulse when a job finishes
//   owner     id of the requester whose job is finishing
//   gnt[1:0]  one-hot grant, all zero when nobody requests
//   gnt_id    encoded grant
module rr_arb2
    import mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       owner,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic ptr_r;

    // Round-robin pointer: after a job the other requester gets first pick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= ~owner;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Grant selection.
    always_comb begin
        gnt_id = 1'b0;
`ifdef MAC_SCHED_PRIO_EN
        if (req[0]) begin
            gnt_id = 1'b0;
        end else begin
            gnt_id = 1'b1;
        end
`else
        if (req[ptr_r]) begin
            gnt_id = ptr_r;
        end else begin
            gnt_id = ~ptr_r;
        end
`endif
        if (req == 2'b00) begin
            gnt = 2'b00;
        end else if (gnt_id) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b01;
        end
    end

endmodule

// File: rtl/mac_sched.sv
// mac_sched: schedules jobs from two requesters onto one shared 4x4-bit MAC.
// A job is LEN operand pairs; the block clears the accumulator, streams the
// granted requester's pairs to the MAC, waits one cycle for the accumulator
// to settle and returns the sum tagged with the requester id.
//
// Configuration macro: MAC_SCHED_PRIO_EN (fixed priority instead of
// round-robin, implemented inside rr_arb2).
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   reqN_valid/reqN_a/reqN_b    operand pair stream from requester N
//   reqN_ready                  pair accepted (only in RUN, only the owner)
//   mac_clr                     one-cycle accumulator clear
//   mac_en, mac_a, mac_b        accumulate strobe and operands
//   mac_acc                     registered accumulator value from the MAC
//   res_valid/res_id/res_data   one-cycle result strobe, owner, sum
//   busy                        high whenever the FSM is not IDLE
module mac_sched
    import mac_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W_IN-1:0]  req0_a,
    input  logic [W_IN-1:0]  req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W_IN-1:0]  req1_a,
    input  logic [W_IN-1:0]  req1_b,
    output logic             req1_ready,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [W_IN-1:0]  mac_a,
    output logic [W_IN-1:0]  mac_b,
    input  logic [W_ACC-1:0] mac_acc,
    output logic             res_valid,
    output logic             res_id,
    output logic [W_ACC-1:0] res_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LEN - 1);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ID_W-1:0]   grant_r;
    logic              req0_ready_r;
    logic              req1_ready_r;
    logic              mac_clr_r;
    logic              res_valid_r;
    logic              res_id_r;
    logic [W_ACC-1:0]  res_data_r;
    logic              busy_r;

    logic [1:0]        arb_gnt_s;
    logic              arb_gnt_id_s;
    logic              sel_valid_s;
    logic [W_IN-1:0]   sel_a_s;
    logic [W_IN-1:0]   sel_b_s;
    logic              beat_s;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (state_r == DONE),
        .owner   (grant_r),
        .gnt     (arb_gnt_s),
        .gnt_id  (arb_gnt_id_s)
    );

    // Route the granted requester's stream towards the MAC.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_a_s     = {W_IN{1'b0}};
        sel_b_s     = {W_IN{1'b0}};
        if (grant_r == 1'b1) begin
            sel_valid_s = req1_valid;
            sel_a_s     = req1_a;
            sel_b_s     = req1_b;
        end else begin
            sel_valid_s = req0_valid;
            sel_a_s     = req0_a;
            sel_b_s     = req0_b;
        end
    end

    // A ready register is only ever set for the owner during RUN, so the
    // OR of both is the owner's ready.
    assign beat_s = sel_valid_s & (req0_ready_r | req1_ready_r);

    assign mac_en     = beat_s;
    assign mac_a      = beat_s ? sel_a_s : {W_IN{1'b0}};
    assign mac_b      = beat_s ? sel_b_s : {W_IN{1'b0}};
    assign req0_ready = req0_ready_r;
    assign req1_ready = req1_ready_r;
    assign mac_clr    = mac_clr_r;
    assign res_valid  = res_valid_r;
    assign res_id     = res_id_r;
    assign res_data   = res_data_r;
    assign busy       = busy_r;

    // Job FSM with beat counter and registered control/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            grant_r      <= 1'b0;
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            mac_clr_r    <= 1'b0;
            res_valid_r  <= 1'b0;
            res_id_r     <= 1'b0;
            res_data_r   <= {W_ACC{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (arb_gnt_s != 2'b00) begin
                        grant_r   <= arb_gnt_id_s;
                        mac_clr_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= CLR;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CLR: begin
                    mac_clr_r    <= 1'b0;
                    cnt_r        <= {CNT_W{1'b0}};
                    req0_ready_r <= (grant_r == 1'b0);
                    req1_ready_r <= (grant_r == 1'b1);
                    state_r      <= RUN;
                end
                RUN: begin
                    if (beat_s) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_BEAT) begin
                            req0_ready_r <= 1'b0;
                            req1_ready_r <= 1'b0;
                            state_r      <= WAIT;
                        end else begin
                            state_r      <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                WAIT: begin
                    // The last beat's update is visible on mac_acc now.
                    res_valid_r <= 1'b1;
                    res_data_r  <= mac_acc;
                    res_id_r    <= grant_r;
                    state_r     <= DONE;
                end
                DONE: begin
                    res_valid_r <= 1'b0;
                    res_data_r  <= {W_ACC{1'b0}};
                    res_id_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    req0_ready_r <= 1'b0;
                    req1_ready_r <= 1'b0;
                    mac_clr_r    <= 1'b0;
                    res_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched: a LEN=4 instance covers arbitration, stalls,
// overlapping requests and mid-job reset; a LEN=20 instance covers wrap.
// Both instances are closed by a behavioural MAC that the reset never touches.
module tb_mac_sched;

    typedef struct {
        logic        id;
        logic [11:0] data;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  v = 3'b000;            // [0],[1] DUT A requesters, [2] DUT B requester 0
    logic [3:0]  opa [3];
    logic [3:0]  opb [3];
    logic [2:0]  rdy;

    // DUT A signals
    logic        a_r0_ready, a_r1_ready, a_clr, a_en, a_rv, a_rid, a_busy;
    logic [3:0]  a_ma, a_mb;
    logic [11:0] a_acc = 12'd0, a_rdata;
    // DUT B signals
    logic        b_r0_ready, b_r1_ready, b_clr, b_en, b_rv, b_rid, b_busy;
    logic [3:0]  b_ma, b_mb;
    logic [11:0] b_acc = 12'd0, b_rdata;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   en_cnt = 0;
    int   clr_cyc = -1;
    int   inv_bad = 0;
    int   start_cyc [3];
    logic prev_rv = 1'b0;
    res_t qa [$];
    res_t qb [$];

    always #5 clk = ~clk;

    mac_sched #(.LEN(4)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_a(opa[0]), .req0_b(opb[0]), .req0_ready(a_r0_ready),
        .req1_valid(v[1]), .req1_a(opa[1]), .req1_b(opb[1]), .req1_ready(a_r1_ready),
        .mac_clr(a_clr), .mac_en(a_en), .mac_a(a_ma), .mac_b(a_mb), .mac_acc(a_acc),
        .res_valid(a_rv), .res_id(a_rid), .res_data(a_rdata), .busy(a_busy)
    );

    mac_sched #(.LEN(20)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(v[2]), .req0_a(opa[2]), .req0_b(opb[2]), .req0_ready(b_r0_ready),
        .req1_valid(1'b0), .req1_a(4'd0), .req1_b(4'd0), .req1_ready(b_r1_ready),
        .mac_clr(b_clr), .mac_en(b_en), .mac_a(b_ma), .mac_b(b_mb), .mac_acc(b_acc),
        .res_valid(b_rv), .res_id(b_rid), .res_data(b_rdata), .busy(b_busy)
    );

    assign rdy = {b_r0_ready, a_r1_ready, a_r0_ready};

    // Behavioural MACs: clear has priority, 12-bit wrapping sum.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_clr)     a_acc <= 12'd0;
        else if (a_en) a_acc <= a_acc + {4'd0, 8'(a_ma) * 8'(a_mb)};
        if (b_clr)     b_acc <= 12'd0;
        else if (b_en) b_acc <= b_acc + {4'd0, 8'(b_ma) * 8'(b_mb)};
    end

    // Result capture and protocol invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_rv) qa.push_back('{a_rid, a_rdata, cyc});
        if (b_rv) qb.push_back('{b_rid, b_rdata, cyc});
        if (a_en) en_cnt = en_cnt + 1;
        if (a_clr) clr_cyc = cyc;
        if (a_r0_ready && a_r1_ready) inv_bad = inv_bad + 1;
        if (a_en && !a_busy) inv_bad = inv_bad + 1;
        if (a_rv && prev_rv) inv_bad = inv_bad + 1;
        prev_rv = a_rv;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Stream n pairs (nibble i of pa/pb) on requester id; optional valid gap
    // of gap_len cycles after beat gap_after. Starts and ends on a negedge.
    task automatic send(input int id, input int n, input logic [79:0] pa,
                        input logic [79:0] pb, input int gap_after, input int gap_len);
        int k;
        for (int i = 0; i < n; i++) begin
            opa[id] = pa[4*i +: 4];
            opb[id] = pb[4*i +: 4];
            v[id]   = 1'b1;
            if (i == 0) start_cyc[id] = cyc;
            k = 0;
            while (!rdy[id] && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (!rdy[id]) begin
                check("ready_wait", {31'd0, rdy[id]}, 32'd1);
                break;
            end
            @(negedge clk);
            if (gap_len > 0 && i + 1 == gap_after) begin
                v[id] = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
        end
        v[id]   = 1'b0;
        opa[id] = 4'd0;
        opb[id] = 4'd0;
    endtask

    // Pop the next result of a DUT and compare id, data and (optionally) cycle.
    task automatic expect_res(input int dut, input string tag, input logic id,
                              input logic [11:0] data, input int exp_cyc);
        int   k = 0;
        res_t r;
        while (((dut == 0) ? qa.size() : qb.size()) == 0 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_seen"}, ((dut == 0) ? qa.size() : qb.size()) > 0 ? 32'd1 : 32'd0, 32'd1);
        if (((dut == 0) ? qa.size() : qb.size()) > 0) begin
            r = (dut == 0) ? qa.pop_front() : qb.pop_front();
            check({tag, "_id"}, {31'd0, r.id}, {31'd0, id});
            check({tag, "_data"}, {20'd0, r.data}, {20'd0, data});
            if (exp_cyc >= 0) check({tag, "_cycle"}, r.cyc, exp_cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        qa.delete();
        qb.delete();
        en_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1hi;
        for (int i = 0; i < 3; i++) begin
            opa[i] = 4'd0;
            opb[i] = 4'd0;
        end
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {5'd0, a_r0_ready, a_r1_ready, a_clr, a_en, a_ma, a_mb,
                             a_rv, a_rid, a_rdata, a_busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Requester 0 alone: 15+14+225+1 = 255, result 7 cycles after t
        en_cnt = 0;
        send(0, 4, 80'h1F23, 80'h1F75, 0, 0);
        expect_res(0, "single", 1'b0, 12'd255, start_cyc[0] + 7);
        check("single_clr_lat", clr_cyc - start_cyc[0], 32'd1);
        check("single_en_cnt", en_cnt, 32'd4);

        // Both valid together after reset, requester 0 re-requests at once
        do_reset();
        fork
            begin
                send(0, 4, {20{4'd1}}, {20{4'd2}}, 0, 0);
                send(0, 4, {20{4'd1}}, {20{4'd2}}, 0, 0);
            end
            send(1, 4, {20{4'd1}}, {20{4'd2}}, 0, 0);
        join
        expect_res(0, "both_1st", 1'b0, 12'd8, -1);
`ifdef MAC_SCHED_PRIO_EN
        expect_res(0, "both_2nd", 1'b0, 12'd8, -1);
        expect_res(0, "both_3rd", 1'b1, 12'd8, -1);
`else
        expect_res(0, "both_2nd", 1'b1, 12'd8, -1);
        expect_res(0, "both_3rd", 1'b0, 12'd8, -1);
`endif

        // Valid low for 2 cycles after beat 2: same sum, 2 cycles later
        do_reset();
        send(0, 4, 80'h1F23, 80'h1F75, 2, 2);
        expect_res(0, "stall", 1'b0, 12'd255, start_cyc[0] + 9);
        check("stall_en_cnt", en_cnt, 32'd4);

        // Requester 1 arrives during requester 0's RUN
        do_reset();
        r1hi = 0;
        fork
            send(0, 4, 80'h1F23, 80'h1F75, 0, 0);
            begin
                repeat (3) @(negedge clk);
                send(1, 4, {20{4'd1}}, {20{4'd2}}, 0, 0);
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    if (a_r1_ready) r1hi++;
                    @(negedge clk);
                end
            end
        join
        check("late_r1_ready_low", r1hi, 32'd0);
        check("late_r1_clr_cycle", clr_cyc - start_cyc[0], 32'd9);
        expect_res(0, "late_r0", 1'b0, 12'd255, start_cyc[0] + 7);
        expect_res(0, "late_r1", 1'b1, 12'd8, -1);

        // Reset after 2 beats: outputs clear, no result, next job is clean
        do_reset();
        send(0, 2, 80'h1F23, 80'h1F75, 0, 0);
        rst = 1'b0;
        #1;
        check("abort_outs", {5'd0, a_r0_ready, a_r1_ready, a_clr, a_en, a_ma, a_mb,
                             a_rv, a_rid, a_rdata, a_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_result", qa.size(), 32'd0);
        send(0, 4, {20{4'd2}}, {20{4'd3}}, 0, 0);
        expect_res(0, "after_abort", 1'b0, 12'd24, -1);

        // LEN=20 of (15,15): 4500 mod 4096 = 404
        send(2, 20, {20{4'd15}}, {20{4'd15}}, 0, 0);
        expect_res(1, "wrap", 1'b0, 12'd404, start_cyc[2] + 23);

        check("invariants", inv_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
